// File: rtl/regfile_scb.sv
// ============================================================================
// Module      : regfile_scb
// Description : Parametrised integer register file with a per-register busy
//               scoreboard, a valid/ready issue port, a flush input and a
//               multi-cycle clear sequencer. Register 0 reads as zero.
//               Optional write-to-read forwarding: REGFILE_SCB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scb #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NRD*AW-1:0]    i_rs_addr,
    output logic [NRD*XLEN-1:0]  o_rs_data,
    output logic [NRD-1:0]       o_rs_busy,
    input  logic [AW-1:0]        i_rd_addr,
    input  logic [XLEN-1:0]      i_rd_data,
    input  logic                 i_rd_wren,
    input  logic                 i_iss_valid,
    input  logic [AW-1:0]        i_iss_rd,
    output logic                 o_iss_ready,
    input  logic                 i_flush,
    input  logic                 i_clear,
    output logic                 o_clear_busy
);

    localparam logic [0:0]    c_ST_IDLE  = 1'b0;
    localparam logic [0:0]    c_ST_CLEAR = 1'b1;
    localparam logic [AW-1:0] c_LAST_IDX = AW'(NREG - 1);

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [AW-1:0]   r_clr_idx;
    logic [AW-1:0]   w_clr_idx_nxt;

    logic            w_idle;
    logic            w_clr_start;
    logic            w_wr_en;
    logic            w_iss_ready;
    logic            w_iss_acc;
    logic            w_busy_clr_all;

    logic [XLEN-1:0] w_rf [NREG];
    logic [NREG-1:0] w_busy;

    assign w_idle         = (r_state == c_ST_IDLE);
    assign w_clr_start    = w_idle && i_clear;
    // Writeback is only honoured while idle; x0 writes are dropped here
    assign w_wr_en        = i_rd_wren && w_idle && (i_rd_addr != '0);
    // A writeback to the same register in this cycle frees it for reissue
    assign w_iss_ready    = w_idle && !i_clear &&
                            ((i_iss_rd == '0) || !w_busy[i_iss_rd] ||
                             (w_wr_en && (i_rd_addr == i_iss_rd)));
    assign w_iss_acc      = i_iss_valid && w_iss_ready && (i_iss_rd != '0);
    assign w_busy_clr_all = i_flush || w_clr_start;

    assign o_iss_ready    = w_iss_ready;
    assign o_clear_busy   = (r_state == c_ST_CLEAR);

    // Sequencer state and clear index register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= c_ST_IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // Sequencer next state: walk indices 1..NREG-1, then return to idle
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            c_ST_IDLE: begin
                if (i_clear) begin
                    w_state_nxt   = c_ST_CLEAR;
                    w_clr_idx_nxt = AW'(1);
                end
            end
            c_ST_CLEAR: begin
                if (r_clr_idx == c_LAST_IDX) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_clr_idx_nxt = '0;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + AW'(1);
                end
            end
            default: begin
                w_state_nxt   = c_ST_IDLE;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    assign w_rf[0]   = '0;
    assign w_busy[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_reg
            localparam logic [AW-1:0] c_IDX = AW'(gi);
            logic [XLEN-1:0] r_data;
            logic            r_busy;

            // Data: writeback while idle, zeroed when the sequencer reaches it
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_data <= '0;
                end else if (w_wr_en && (i_rd_addr == c_IDX)) begin
                    r_data <= i_rd_data;
                end else if (!w_idle && (r_clr_idx == c_IDX)) begin
                    r_data <= '0;
                end
            end

            // Busy: flush/clear-start beats issue-set, which beats writeback-clear
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_busy <= 1'b0;
                end else if (w_busy_clr_all) begin
                    r_busy <= 1'b0;
                end else if (w_iss_acc && (i_iss_rd == c_IDX)) begin
                    r_busy <= 1'b1;
                end else if (w_wr_en && (i_rd_addr == c_IDX)) begin
                    r_busy <= 1'b0;
                end
            end

            assign w_rf[gi]   = r_data;
            assign w_busy[gi] = r_busy;
        end
    endgenerate

    genvar gk;
    generate
        for (gk = 0; gk < NRD; gk++) begin : g_rd
            logic [AW-1:0] w_addr;
            assign w_addr = i_rs_addr[gk*AW +: AW];
`ifdef REGFILE_SCB_BYPASS_EN
            // Forward the in-flight writeback to a matching read port
            logic w_fwd;
            assign w_fwd = w_wr_en && (i_rd_addr == w_addr);
            assign o_rs_data[gk*XLEN +: XLEN] = w_fwd ? i_rd_data : w_rf[w_addr];
            assign o_rs_busy[gk] = w_fwd ? (w_iss_acc && (i_iss_rd == w_addr))
                                         : w_busy[w_addr];
`else
            assign o_rs_data[gk*XLEN +: XLEN] = w_rf[w_addr];
            assign o_rs_busy[gk]              = w_busy[w_addr];
`endif
        end
    endgenerate

endmodule

`default_nettype wire

// File: doc/regfile_scb.md
Name: regfile_scb

Overview:
- Parametrised successor to the core integer register file, with configurable width, depth and read-port count.
- Adds a per-register busy scoreboard with a valid/ready issue handshake, a flush input, and a multi-cycle clear sequencer.
- Sits between decode/issue (read ports, issue port) and writeback (write port) in the pipelined core.
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register in bits.
- NREG, 32, number of registers; a power of two, at least 2. AW = log2(NREG).
- NRD, 2, number of read ports, 1..4.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous reset, active-high.
- i_rs_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- o_rs_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- o_rs_busy  out  NRD  port k: the busy bit of the register it addresses.
- i_rd_addr  in  AW  writeback address.
- i_rd_data  in  XLEN  writeback data.
- i_rd_wren  in  1  writeback enable.
- i_iss_valid  in  1  issue request; reserves i_iss_rd.
- i_iss_rd  in  AW  destination register being issued.
- o_iss_ready  out  1  issue is accepted when i_iss_valid && o_iss_ready.
- i_flush  in  1  clears all busy bits.
- i_clear  in  1  starts the clear sequencer.
- o_clear_busy  out  1  high while the sequencer runs.

Behaviour:
- Reset (async, active-high):
  - all registers 0, all busy bits 0, FSM in IDLE, clear index 0.
  - outputs: o_rs_busy=0, o_clear_busy=0, o_iss_ready=1, o_rs_data=0.
- Reads are combinational from the addresses.
  - Address 0 always returns data 0 and busy 0.
  - Any number of ports may read the same address in the same cycle.
- Writeback: when i_rd_wren=1, i_rd_addr!=0 and the FSM is IDLE:
  - reg[i_rd_addr] <= i_rd_data;
  - busy[i_rd_addr] <= 0.
  - A write to address 0 is discarded and has no effect on busy.
- Issue:
  - o_iss_ready = (FSM==IDLE) && !i_clear && (i_iss_rd==0 || !busy[i_iss_rd] || writeback to i_iss_rd this cycle).
  - On accept with i_iss_rd!=0: busy[i_iss_rd] <= 1. Issue to x0 is always accepted when IDLE and never sets busy.
- Priority on the same register in one cycle: issue-set beats writeback-clear, so the register ends busy and holds the written data.
- Priority across sources: i_flush beats issue-set. With flush, issue and writeback in one cycle, the data write still happens and all busy bits end 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when i_clear=1. That edge clears all busy bits and sets index=1.
  - In CLEAR, each cycle: reg[index] <= 0, index++.
  - CLEAR -> IDLE after writing index NREG-1, so CLEAR lasts NREG-1 cycles.
  - o_clear_busy=1 exactly while in CLEAR.
  - Reads stay live during CLEAR (partially cleared contents are visible).
  - Writes are ignored during CLEAR; o_iss_ready=0.
  - i_clear while already in CLEAR is ignored (no restart).
- Reset asserted mid-CLEAR: immediate return to IDLE, all registers 0.
- Width rules: the clear index is AW bits, and wrap from NREG-1 is never reached. No arithmetic on data.

Optional Feature:
- Macro: REGFILE_SCB_BYPASS_EN.
- Defined: write-to-read forwarding. When i_rd_wren=1, FSM is IDLE, i_rd_addr!=0 and i_rd_addr matches read port k, then:
  - o_rs_data[k] = i_rd_data in the same cycle;
  - o_rs_busy[k] = 0 in that cycle, unless an issue to the same register is accepted that cycle (then 1).
- Not defined: reads return stored contents and the registered busy bit. New data is visible the cycle after the write edge.

Test Plan:
- Reset: assert i_reset mid-cycle, then release. Read ports 0..NRD-1 at x5 -> data 0, busy 0. o_iss_ready=1, o_clear_busy=0.
- Write/x0 check:
  - wren, x3 <= 0xDEADBEEF, read x3 next cycle -> 0xDEADBEEF, busy 0.
  - wren, x0 <= 0x1234 -> read x0 = 0.
- Scoreboard:
  - issue x7 -> busy[x7]=1; second issue x7 -> o_iss_ready=0.
  - Writeback x7=0x55 -> busy 0 and data 0x55.
  - Issue and writeback of x7 in the same cycle -> busy stays 1, data updated.
- Flush: issue x1, x2, x9 -> all busy. i_flush=1 for one cycle -> all busy 0, data unchanged.
- Clear sequencer:
  - Fill x1..x31 with the value i, pulse i_clear.
  - Expect o_clear_busy high for exactly 31 cycles; writes in that window are ignored; afterwards all reads = 0.
  - Reset asserted at cycle 10 of CLEAR -> IDLE immediately, all registers 0.
- Bypass: write x4=0xA5A5A5A5 while reading x4 on port 1. With REGFILE_SCB_BYPASS_EN defined -> same-cycle 0xA5A5A5A5. Without it -> old value, then the new value the next cycle.
